// File: rtl/euler1_result_ascii.sv
`default_nettype none
// ----------------------------------------------------------------------------
// euler1_result_ascii : captures the 24-bit Problem 1 sum, converts it to BCD
// with a sequential double-dabble and streams ASCII digits (+ CR LF).
// Revision: 1.0
// ----------------------------------------------------------------------------
module euler1_result_ascii #(
  parameter int EMIT_EOL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        results_valid,
  input  logic [23:0] results,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_EMIT    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    P_DIGIT = 2'd0,
    P_CR    = 2'd1,
    P_LF    = 2'd2
  } phase_t;

  localparam logic       HAS_EOL  = (EMIT_EOL != 0);
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  state_t      state;
  phase_t      phase;
  logic        prev_valid;
  logic [23:0] bin;
  logic [31:0] bcd;
  logic [4:0]  iter;
  logic [2:0]  digit_idx;

  logic [31:0] bcd_adj;
  logic [55:0] shifted;
  logic [2:0]  lead_idx;
  logic [2:0]  next_idx;
  logic [3:0]  lead_digit;
  logic [3:0]  next_digit;
  logic        capture;
  logic        xfer;

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 8; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      else                       bcd_adj[i*4 +: 4] = bcd[i*4 +: 4];
    end
    shifted = {bcd_adj, bin} << 1;
  end

  // Highest nonzero digit; stays 0 for a zero value so "0" is still sent.
  always_comb begin
    lead_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) lead_idx = i[2:0];
    end
  end

  assign next_idx   = digit_idx - 3'd1;
  assign lead_digit = bcd[{lead_idx, 2'b00} +: 4];
  assign next_digit = bcd[{next_idx, 2'b00} +: 4];
  assign capture    = (state == S_IDLE) && results_valid && !prev_valid;
  assign xfer       = char_valid && char_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= P_DIGIT;
      prev_valid <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      iter       <= '0;
      digit_idx  <= '0;
      char_valid <= 1'b0;
      char_data  <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      prev_valid <= results_valid;
      case (state)
        S_IDLE: begin
          if (capture) begin
            // First iteration folded into capture: BCD is zero, so it is a pure shift.
            bcd   <= {31'd0, results[23]};
            bin   <= {results[22:0], 1'b0};
            iter  <= 5'd0;
            busy  <= 1'b1;
            state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (iter == 5'd23) begin
            digit_idx  <= lead_idx;
            phase      <= P_DIGIT;
            char_data  <= {4'h3, lead_digit};
            char_valid <= 1'b1;
            state      <= S_EMIT;
          end else begin
            bcd  <= shifted[55:24];
            bin  <= shifted[23:0];
            iter <= iter + 5'd1;
          end
        end
        S_EMIT: begin
          if (xfer) begin
            if (phase == P_DIGIT && digit_idx != 3'd0) begin
              digit_idx <= next_idx;
              char_data <= {4'h3, next_digit};
            end else if (phase == P_DIGIT && HAS_EOL) begin
              phase     <= P_CR;
              char_data <= ASCII_CR;
            end else if (phase == P_CR) begin
              phase     <= P_LF;
              char_data <= ASCII_LF;
            end else begin
              char_valid <= 1'b0;
              char_data  <= 8'h00;
              done       <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_euler1_result_ascii.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_euler1_result_ascii : scoreboard bench for euler1_result_ascii, with and
// without CR LF, driven by directed and $urandom values.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_euler1_result_ascii;

  logic            clk;
  logic            reset;
  logic            results_valid;
  logic [23:0]     results;
  logic            char_ready;
  logic [1:0]      cv;
  logic [1:0][7:0] cd;
  logic [1:0]      bz;
  logic [1:0]      dn;

  int compared   = 0;
  int mismatched = 0;

  // Expected bytes per DUT: bit 8 marks the final byte of a string.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit   [1:0] exp_done;
  bit   [1:0] exp_idle;
  bit   [1:0] stall;
  logic [1:0][7:0] held;
  bit         mon_en = 0;

  euler1_result_ascii #(.EMIT_EOL(1)) dut (
    .clk(clk), .reset(reset), .results_valid(results_valid), .results(results),
    .char_valid(cv[0]), .char_data(cd[0]), .char_ready(char_ready),
    .busy(bz[0]), .done(dn[0])
  );

  euler1_result_ascii #(.EMIT_EOL(0)) dut_noeol (
    .clk(clk), .reset(reset), .results_valid(results_valid), .results(results),
    .char_valid(cv[1]), .char_data(cd[1]), .char_ready(char_ready),
    .busy(bz[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    mismatched++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: decimal text of the value, then CR LF when enabled.
  task automatic push_expected(input int d, input logic [23:0] v, input bit eol);
    string s;
    logic [8:0] e;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) begin
      e = {(!eol && i == s.len() - 1), s[i]};
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (eol) begin
      if (d == 0) begin q0.push_back({1'b0, 8'h0D}); q0.push_back({1'b1, 8'h0A}); end
      else        begin q1.push_back({1'b0, 8'h0D}); q1.push_back({1'b1, 8'h0A}); end
    end
  endtask

  task automatic flush();
    q0.delete();
    q1.delete();
    exp_done = '0;
    exp_idle = '0;
    stall    = '0;
  endtask

  // Monitor: mid-cycle sampling; a byte transfers at the next rising edge.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [8:0] e;
        if (exp_idle[d]) begin
          check($sformatf("dut%0d_busy_after_done", d), bz[d], 0);
          check($sformatf("dut%0d_done_width", d), dn[d], 0);
          exp_idle[d] = 1'b0;
        end else if (exp_done[d]) begin
          check($sformatf("dut%0d_done_pulse", d), dn[d], 1);
          check($sformatf("dut%0d_valid_in_done", d), cv[d], 0);
          check($sformatf("dut%0d_busy_in_done", d), bz[d], 1);
          exp_done[d] = 1'b0;
          exp_idle[d] = 1'b1;
        end else if (dn[d]) begin
          note_fail($sformatf("dut%0d_spurious_done", d), dn[d], 0);
        end
        if (stall[d]) begin
          check($sformatf("dut%0d_stall_valid", d), cv[d], 1);
          check($sformatf("dut%0d_stall_data", d), cd[d], held[d]);
        end
        if (cv[d] && char_ready) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            note_fail($sformatf("dut%0d_unexpected_byte", d), cd[d], 0);
          end else begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            check($sformatf("dut%0d_byte", d), cd[d], e[7:0]);
            if (e[8]) exp_done[d] = 1'b1;
          end
        end
        stall[d] = cv[d] && !char_ready;
        held[d]  = cd[d];
      end
    end
  end

  // rmode: 0 = ready always high, 1 = ~50% random, 2 = ready low.
  task automatic tick(input int rmode);
    @(posedge clk);
    #1;
    char_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom % 2) : 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bz != 2'b00 || dn != 2'b00) && n < 500) begin
      tick(0);
      n++;
    end
    if (n >= 500) note_fail("idle_timeout", {30'd0, bz}, 0);
  endtask

  task automatic check_reset_values();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_rst_valid", d), cv[d], 0);
      check($sformatf("dut%0d_rst_data", d), cd[d], 0);
      check($sformatf("dut%0d_rst_busy", d), bz[d], 0);
      check($sformatf("dut%0d_rst_done", d), dn[d], 0);
    end
  endtask

  // Follows one string from the capture edge (the next rising edge) to idle.
  task automatic follow(input int rmode, input bit toggle, input int hold);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 3000) begin
      tick(rmode);
      n++;
      for (int d = 0; d < 2; d++) begin
        if (n == 1)  check($sformatf("dut%0d_busy_at_capture", d), bz[d], 1);
        if (n == 24) check($sformatf("dut%0d_latency_pre", d), cv[d], 0);
        if (n == 25) check($sformatf("dut%0d_latency_first", d), cv[d], 1);
      end
      if (toggle) begin
        if (n == 4 || n == 26) results_valid = 1'b0;
        if (n == 7 || n == 27) results_valid = 1'b1;
      end else if (hold == 0 && n == 2) begin
        results_valid = 1'b0;
      end
      if (dn[0]) seen = 1;
    end
    if (!seen) note_fail("done_timeout", n, 0);
    while (n < hold) begin
      tick(rmode);
      n++;
    end
    results_valid = 1'b0;
    tick(rmode);
    tick(rmode);
    check("dut0_busy_idle", bz[0], 0);
    check("dut1_busy_idle", bz[1], 0);
    check("dut0_drained", q0.size(), 0);
    check("dut1_drained", q1.size(), 0);
  endtask

  task automatic run_value(input logic [23:0] v, input int rmode, input bit toggle, input int hold);
    wait_idle();
    push_expected(0, v, 1'b1);
    push_expected(1, v, 1'b0);
    results       = v;
    results_valid = 1'b1;
    follow(rmode, toggle, hold);
  endtask

  // Reset after two bytes of "233168" have transferred.
  task automatic mid_reset(input bit keep_valid);
    wait_idle();
    push_expected(0, 24'd233168, 1'b1);
    push_expected(1, 24'd233168, 1'b0);
    results       = 24'd233168;
    results_valid = 1'b1;
    for (int n = 1; n <= 27; n++) begin
      tick(0);
      if (n == 2 && !keep_valid) results_valid = 1'b0;
    end
    reset      = 1'b1;
    char_ready = 1'b0;
    tick(2);
    flush();
    check_reset_values();
    reset = 1'b0;
    if (keep_valid) begin
      push_expected(0, 24'd233168, 1'b1);
      push_expected(1, 24'd233168, 1'b0);
      follow(0, 1'b0, 0);
    end else begin
      repeat (40) tick(0);
      check("dut0_quiet_after_reset", bz[0], 0);
      check("dut1_quiet_after_reset", bz[1], 0);
    end
  endtask

  initial begin
    logic [23:0] v;
    logic [23:0] mask;
    reset         = 1'b1;
    results_valid = 1'b0;
    results       = '0;
    char_ready    = 1'b0;
    flush();
    repeat (3) tick(2);
    check_reset_values();
    reset  = 1'b0;
    mon_en = 1;

    run_value(24'd233168,   0, 1'b0, 0);
    run_value(24'd0,        0, 1'b0, 0);
    run_value(24'd16777215, 0, 1'b0, 0);
    run_value(24'd10000000, 0, 1'b0, 0);
    run_value(24'd23,       1, 1'b0, 0);
    run_value(24'd23,       1, 1'b0, 0);
    run_value(24'd233168,   0, 1'b0, 200);
    run_value(24'd233168,   0, 1'b1, 0);
    run_value(24'd987654,   1, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      mask = 24'hFFFFFF >> (24 - $urandom_range(1, 24));
      v    = 24'($urandom) & mask;
      run_value(v, $urandom_range(0, 1), 1'b0, 0);
    end

    mid_reset(1'b0);
    mid_reset(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
